// File: rtl/aes_round_sequencer_if.sv
// Handshake and round-datapath bundle for the AES round sequencer.
// slave = sequencer side, master = environment/datapath side.
interface aes_round_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic [7:0]   rnd_rcon;
  logic         rnd_last;
  logic [127:0] key_next;
  logic [127:0] rnd_data;

  modport slave (
    input  in_valid, in_data, in_key,
    input  out_ready, key_next, rnd_data,
    output in_ready, out_valid, out_data,
    output busy, rnd_state, rnd_key,
    output rnd_rcon, rnd_last
  );

  modport master (
    output in_valid, in_data, in_key,
    output out_ready, key_next, rnd_data,
    input  in_ready, out_valid, out_data,
    input  busy, rnd_state, rnd_key,
    input  rnd_rcon, rnd_last
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: one round per clock
// through an external round datapath and key-expansion step.
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input logic                   CLK,
  input logic                   RST_N,
  aes_round_sequencer_if.slave  bus
);

  localparam logic [3:0] NR_W = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } st_e;

  st_e          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         last_q, last_d;
  logic         ov_q, ov_d;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Next-state: load on accept, advance one round per clock.
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    unique case (st_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.in_data ^ bus.in_key;
          key_d   = bus.in_key;
          rnd_d   = 4'd1;
          rcon_d  = 8'h01;
          st_d    = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = bus.rnd_data;
        key_d   = bus.key_next;
        if (rnd_q == NR_W) begin
          st_d = S_DONE;
        end else begin
          rnd_d  = rnd_q + 4'd1;
          rcon_d = xtime(rcon_q);
        end
      end
      S_DONE: begin
        if (bus.out_ready) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    last_d = (st_d == S_ROUND) && (rnd_d == NR_W);
    ov_d   = (st_d == S_DONE);
  end

  // State and registered status flags; async abort on reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q    <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      rcon_q  <= '0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (st_q == S_IDLE);
  assign bus.busy      = (st_q != S_IDLE);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = ov_q ? state_q : '0;
  assign bus.rnd_state = state_q;
  assign bus.rnd_key   = key_q;
  assign bus.rnd_rcon  = (st_q == S_ROUND) ? rcon_q : 8'h00;
  assign bus.rnd_last  = last_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a golden
// AES round datapath and key expansion.
module tb_aes_round_sequencer;

  logic CLK;
  logic RST_N;
  int   errs;
  int   nchk;
  int   cyc;
  int   acc_cyc;

  aes_round_sequencer_if bus ();

  aes_round_sequencer #(.NR(10)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] rc_tab [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, sq;
    r = 8'h01; sq = a;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k,
                                           input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]),
          sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] st,
                                           input logic [127:0] k,
                                           input logic last);
    logic [7:0] b [16];
    logic [7:0] s [16];
    logic [7:0] m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) m[4*c+r] = s[4*c+r];
      end else begin
        m[4*c]   = gmul(8'h02, s[4*c]) ^ gmul(8'h03, s[4*c+1])
                 ^ s[4*c+2] ^ s[4*c+3];
        m[4*c+1] = s[4*c] ^ gmul(8'h02, s[4*c+1])
                 ^ gmul(8'h03, s[4*c+2]) ^ s[4*c+3];
        m[4*c+2] = s[4*c] ^ s[4*c+1]
                 ^ gmul(8'h02, s[4*c+2]) ^ gmul(8'h03, s[4*c+3]);
        m[4*c+3] = gmul(8'h03, s[4*c]) ^ s[4*c+1]
                 ^ s[4*c+2] ^ gmul(8'h02, s[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i] ^ k[127-8*i -: 8];
    return o;
  endfunction

  assign bus.key_next = key_exp(bus.rnd_key, bus.rnd_rcon);
  assign bus.rnd_data = aes_rnd(bus.rnd_state, bus.key_next, bus.rnd_last);

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] E1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("in_ready_wait", 128'(bus.in_ready), 128'(1'b1));
  endtask

  task automatic do_vec(input logic [127:0] k,
                        input logic [127:0] p,
                        input logic [127:0] e,
                        input int hold,
                        input bit poke);
    wait_ready();
    bus.in_key    = k;
    bus.in_data   = p;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge CLK);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.in_key   = ~k;
    bus.in_data  = ~p;
    for (int r = 0; r < 10; r++) begin
      @(negedge CLK);
      check("rcon", 128'(bus.rnd_rcon), 128'(rc_tab[r]));
      check("last", 128'(bus.rnd_last), 128'(r == 9));
      check("ov_round", 128'(bus.out_valid), 128'(1'b0));
      check("rdy_round", 128'(bus.in_ready), 128'(1'b0));
      bus.in_valid = poke && (r == 4);
    end
    @(negedge CLK);
    bus.in_valid = 1'b0;
    check("ov_done", 128'(bus.out_valid), 128'(1'b1));
    check("ct", bus.out_data, e);
    check("rcon_done", 128'(bus.rnd_rcon), 128'(8'h00));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = poke;
        @(negedge CLK);
        check("ov_hold", 128'(bus.out_valid), 128'(1'b1));
        check("ct_hold", bus.out_data, e);
        check("rdy_hold", 128'(bus.in_ready), 128'(1'b0));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge CLK);
      check("ov_idle", 128'(bus.out_valid), 128'(1'b0));
      check("od_idle", bus.out_data, 128'h0);
      check("rdy_idle", 128'(bus.in_ready), 128'(1'b1));
      check("busy_idle", 128'(bus.busy), 128'(1'b0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;
    logic seen;
    errs          = 0;
    nchk          = 0;
    cyc           = 0;
    RST_N         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_rdy", 128'(bus.in_ready), 128'(1'b1));
    check("rst_ov", 128'(bus.out_valid), 128'(1'b0));
    check("rst_busy", 128'(bus.busy), 128'(1'b0));
    check("rst_state", bus.rnd_state, 128'h0);
    check("rst_key", bus.rnd_key, 128'h0);
    check("rst_rcon", 128'(bus.rnd_rcon), 128'(8'h00));
    check("rst_last", 128'(bus.rnd_last), 128'(1'b0));
    check("rst_od", bus.out_data, 128'h0);
    RST_N = 1'b1;
    @(negedge CLK);

    do_vec(K1, P1, E1, 0, 1'b0);
    do_vec(K2, P2, E2, 0, 1'b0);
    do_vec(K1, P1, E1, 5, 1'b1);

    wait_ready();
    bus.in_key    = K2;
    bus.in_data   = P2;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge CLK);
    check("abort_rnd5", 128'(bus.rnd_rcon), 128'(8'h10));
    #2;
    RST_N = 1'b0;
    #1;
    check("abort_busy", 128'(bus.busy), 128'(1'b0));
    check("abort_rdy", 128'(bus.in_ready), 128'(1'b1));
    check("abort_ov", 128'(bus.out_valid), 128'(1'b0));
    check("abort_state", bus.rnd_state, 128'h0);
    check("abort_key", bus.rnd_key, 128'h0);
    check("abort_rcon", 128'(bus.rnd_rcon), 128'(8'h00));
    check("abort_last", 128'(bus.rnd_last), 128'(1'b0));
    @(negedge CLK);
    RST_N = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      seen = seen | bus.out_valid;
    end
    check("abort_no_ov", 128'(seen), 128'(1'b0));
    do_vec(K1, P1, E1, 0, 1'b0);

    do_vec(K1, P1, E1, 0, 1'b0);
    a0 = acc_cyc;
    do_vec(K2, P2, E2, 0, 1'b0);
    a1 = acc_cyc;
    do_vec(K1, P1, E1, 0, 1'b0);
    a2 = acc_cyc;
    check("b2b_gap1", 128'(a1 - a0), 128'(12));
    check("b2b_gap2", 128'(a2 - a1), 128'(12));

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
